dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer for the byte-addressed 1 KiB data memory (`dmem`). It shares the single memory port between port 0 (CPU load/store unit) and port 1 (debug/DMA loader) using round-robin arbitration and a req/ack handshake. It drives the memory's chip-select, read and width-specific write strobes, and returns size-extracted read data. It also rejects misaligned and out-of-range accesses without touching memory.

## Interface
- `ADDR_W`, 11, byte address width (matches `DM_addr`)
- `MEM_BYTES`, 1024, implemented memory size; accesses ending at or beyond this are errors
- `clk` in 1, single clock; everything is rising-edge
- `rst` in 1, synchronous, active-high reset
- `m0_req` / `m1_req` in 1, access request; held until the matching ack
- `m0_we` / `m1_we` in 1, 1 = store, 0 = load
- `m0_size` / `m1_size` in 2, 00 byte, 01 half, 10 word, 11 illegal
- `m0_addr` / `m1_addr` in ADDR_W, byte address
- `m0_wdata` / `m1_wdata` in 32, store data, right-aligned (byte in [7:0], half in [15:0])
- `m0_ack` / `m1_ack` out 1, one-cycle completion pulse
- `m0_rdata` / `m1_rdata` out 32, load data; valid in the ack cycle and held until the next ack on that port
- `m0_err` / `m1_err` out 1, qualifies ack; 1 = rejected, memory untouched
- `busy` out 1, high whenever state ≠ IDLE
- `cs`, `DM_R`, `DM_W_W`, `DM_W_H`, `DM_W_B` out 1 each, memory controls (all registered)
- `DM_addr` out ADDR_W, registered memory address
- `DM_data_in` out 32, registered store data
- `DM_data_out` in 32, memory read data (combinational from `DM_addr`)

## Operation
- FSM states:
  - IDLE: if any req, arbitrate and latch winner's we/size/addr/wdata. Go to ACCESS, or to RESP directly with err if the check fails.
  - ACCESS: memory controls asserted for exactly one cycle. Capture `DM_data_out` at the end of the cycle. Go to RESP.
  - RESP: pulse the winner's ack (and err if flagged), then go to IDLE.
- Arbitration:
  - Single requester wins.
  - Both requesting: the port not granted last wins.
  - `last_grant` updates on each grant and resets to 1, so port 0 wins the first contention.
- Error check, evaluated on the latched request:
  - size = 11 is an error.
  - half with addr[0] ≠ 0 is an error.
  - word with addr[1:0] ≠ 0 is an error.
  - addr + bytes > MEM_BYTES is an error.
  - On error: no strobe or cs, rdata = 0, err = 1.
- Strobe mapping in ACCESS:
  - cs = 1 always.
  - Load: DM_R = 1.
  - Store: exactly one of DM_W_B / DM_W_H / DM_W_W per size.
  - Never read and write in the same cycle.
- Read extraction:
  - byte → {24'b0, DM_data_out[7:0]}
  - half → {16'b0, DM_data_out[15:0]}
  - word → full 32 bits
  - Sign extension is the CPU's job.
- Store data: passed to `DM_data_in` unmodified. Memory writes only the low bytes per strobe.
- Outside ACCESS, all memory controls = 0. `DM_addr` / `DM_data_in` hold their last value.

## Timing
- Reset values: all strobes, cs, acks, errs, busy = 0; rdata = 0; `DM_addr` = 0; `DM_data_in` = 0; state IDLE; `last_grant` = 1.
- Valid access latency: req sampled in IDLE at edge n; ACCESS during cycle n+1; ack high during cycle n+2; IDLE again at n+3.
- Back-to-back throughput: one access per 3 cycles.
- Error latency: ack during cycle n+1 (IDLE → RESP).
- Ack is never asserted on both ports in the same cycle.
- Requester rules:
  - After ack, the requester must drop req or present a new request. A req still high in the cycle after ack is treated as a new request.
  - Request fields are latched at grant. Changing them or dropping req after grant does not affect the in-flight access, and the ack still pulses.
- Store visibility: the store commits at the edge ending ACCESS. A load granted afterwards returns the new data.
- Reset during ACCESS: the write in that cycle still commits, because memory samples the same edge. No ack is issued, and state returns to IDLE.
- Reset during RESP: the ack still shows for that cycle (it is registered), and the next cycle is idle with outputs at reset values.

## Test plan
- Word store/load: port 0 stores 0xDEADBEEF to 0x010, then loads 0x010.
  - Required: DM_W_W for one cycle; load ack at n+2 with rdata 0xDEADBEEF, err 0.
- Sub-word: store byte 0xA5 to 0x013 and half 0x1234 to 0x016, then word load at 0x014.
  - Required: rdata 0x1234xxxx with prior bytes preserved; byte load at 0x013 returns 0x000000A5.
- Contention: both ports hold req continuously from reset.
  - Required: grants alternate 0,1,0,1; acks 3 cycles apart; never simultaneous.
- Errors: half at 0x011, word at 0x402, size 11.
  - Required: each acks at n+1 with err = 1, rdata 0, and cs/strobes stay 0.
- Boundary: word at 0x3FC is legal and reads back correctly; word at 0x3FD errors.
  - Required: the 0x3FC access completes normally; the 0x3FD access returns err = 1 with no memory activity.
- Reset in ACCESS of a store of 0xCAFEF00D.
  - Required: no ack; busy = 0 after reset; a later load of that address returns 0xCAFEF00D.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 1 KiB byte-addressed data memory.
// Each access runs IDLE -> ACCESS -> RESP; rejected requests skip ACCESS and never touch memory.
module dmem_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,

  output logic              busy,
  output logic              cs,
  output logic              DM_R,
  output logic              DM_W_W,
  output logic              DM_W_H,
  output logic              DM_W_B,
  output logic [ADDR_W-1:0] DM_addr,
  output logic [31:0]       DM_data_in,
  input  logic [31:0]       DM_data_out
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  function automatic logic [ADDR_W:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return (ADDR_W+1)'(1);
      SZ_HALF: return (ADDR_W+1)'(2);
      default: return (ADDR_W+1)'(4);
    endcase
  endfunction

  // Misalignment, the illegal size code, or any byte past the end of memory rejects the access.
  function automatic logic access_bad(input logic [1:0] sz, input logic [ADDR_W-1:0] a);
    logic misaligned;
    case (sz)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = a[0];
      SZ_WORD: misaligned = |a[1:0];
      default: misaligned = 1'b1;
    endcase
    return misaligned || (({1'b0, a} + size_bytes(sz)) > MEM_LIMIT);
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return {24'b0, d[7:0]};
      SZ_HALF: return {16'b0, d[15:0]};
      default: return d;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;

  logic              cs_d, rd_d, ww_d, wh_d, wb_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic              ack0_d, ack1_d, err0_d, err1_d;
  logic [31:0]       rdata0_d, rdata1_d;

  req_t              req0, req1, sel;
  logic              grant;
  logic              sel_bad;
  logic [31:0]       load_data;

  assign req0 = '{we: m0_we, size: m0_size, addr: m0_addr, wdata: m0_wdata};
  assign req1 = '{we: m1_we, size: m1_size, addr: m1_addr, wdata: m1_wdata};

  // Under contention the port that did not win last time goes next.
  assign grant   = (m0_req && m1_req) ? ~last_grant_q : m1_req;
  assign sel     = grant ? req1 : req0;
  assign sel_bad = access_bad(sel.size, sel.addr);

  assign load_data = we_q ? 32'b0 : extract(DM_data_out, size_q);
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can leave one unassigned and infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    size_d       = size_q;
    addr_d       = DM_addr;
    wdata_d      = DM_data_in;
    cs_d         = 1'b0;
    rd_d         = 1'b0;
    ww_d         = 1'b0;
    wh_d         = 1'b0;
    wb_d         = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rdata0_d     = m0_rdata;
    rdata1_d     = m1_rdata;

    unique case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          port_d       = grant;
          last_grant_d = grant;
          we_d         = sel.we;
          size_d       = sel.size;
          if (sel_bad) begin
            state_d = S_RESP;
            if (grant) begin
              ack1_d   = 1'b1;
              err1_d   = 1'b1;
              rdata1_d = 32'b0;
            end else begin
              ack0_d   = 1'b1;
              err0_d   = 1'b1;
              rdata0_d = 32'b0;
            end
          end else begin
            state_d = S_ACCESS;
            addr_d  = sel.addr;
            wdata_d = sel.wdata;
            cs_d    = 1'b1;
            rd_d    = ~sel.we;
            wb_d    = sel.we && (sel.size == SZ_BYTE);
            wh_d    = sel.we && (sel.size == SZ_HALF);
            ww_d    = sel.we && (sel.size == SZ_WORD);
          end
        end
      end

      S_ACCESS: begin
        // Memory read data is combinational from DM_addr, so it is valid to capture here.
        state_d = S_RESP;
        if (port_q) begin
          ack1_d   = 1'b1;
          rdata1_d = load_data;
        end else begin
          ack0_d   = 1'b1;
          rdata0_d = load_data;
        end
      end

      S_RESP: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      cs           <= 1'b0;
      DM_R         <= 1'b0;
      DM_W_W       <= 1'b0;
      DM_W_H       <= 1'b0;
      DM_W_B       <= 1'b0;
      DM_addr      <= '0;
      DM_data_in   <= 32'b0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_err       <= 1'b0;
      m1_err       <= 1'b0;
      m0_rdata     <= 32'b0;
      m1_rdata     <= 32'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      size_q       <= size_d;
      cs           <= cs_d;
      DM_R         <= rd_d;
      DM_W_W       <= ww_d;
      DM_W_H       <= wh_d;
      DM_W_B       <= wb_d;
      DM_addr      <= addr_d;
      DM_data_in   <= wdata_d;
      m0_ack       <= ack0_d;
      m1_ack       <= ack1_d;
      m0_err       <= err0_d;
      m1_err       <= err1_d;
      m0_rdata     <= rdata0_d;
      m1_rdata     <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a byte-array memory behind the DUT, a separate reference byte array
// updated from the access rules, directed cases followed by randomized single-port traffic.
module tb_dmem_arbiter;

  localparam int ADDR_W    = 11;
  localparam int MEM_BYTES = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [1:0]        m0_size, m1_size;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [31:0]       m0_wdata, m1_wdata;
  logic              m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0]       m0_rdata, m1_rdata;
  logic              busy, cs, DM_R, DM_W_W, DM_W_H, DM_W_B;
  logic [ADDR_W-1:0] DM_addr;
  logic [31:0]       DM_data_in, DM_data_out;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem     [0:MEM_BYTES-1] = '{default: 8'h00};
  logic [7:0] ref_mem [0:MEM_BYTES-1] = '{default: 8'h00};

  dmem_arbiter #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .busy(busy), .cs(cs), .DM_R(DM_R), .DM_W_W(DM_W_W), .DM_W_H(DM_W_H), .DM_W_B(DM_W_B),
    .DM_addr(DM_addr), .DM_data_in(DM_data_in), .DM_data_out(DM_data_out)
  );

  always #5 clk = ~clk;

  // Little-endian memory: combinational read, strobed write of the low bytes at the clock edge.
  always_comb begin
    DM_data_out = '0;
    for (int i = 0; i < 4; i++)
      if (int'(DM_addr) + i < MEM_BYTES) DM_data_out[8*i +: 8] = mem[10'(int'(DM_addr) + i)];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if ((DM_W_W || (DM_W_H && i < 2) || (DM_W_B && i == 0)) && (int'(DM_addr) + i < MEM_BYTES))
        mem[10'(int'(DM_addr) + i)] <= DM_data_in[8*i +: 8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_err(input logic [1:0] sz, input int addr);
    if (sz == 2'b11) return 1'b1;
    if (addr % nbytes(sz) != 0) return 1'b1;
    return (addr + nbytes(sz) > MEM_BYTES);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input int addr);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nbytes(sz); i++) v[8*i +: 8] = ref_mem[10'(addr + i)];
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input int addr, input logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[10'(addr + i)] = wd[8*i +: 8];
  endtask

  task automatic drive_port(input int p, input logic req, input logic we, input logic [1:0] sz,
                            input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    if (p == 0) begin
      m0_req = req; m0_we = we; m0_size = sz; m0_addr = a; m0_wdata = wd;
    end else begin
      m1_req = req; m1_we = we; m1_size = sz; m1_addr = a; m1_wdata = wd;
    end
  endtask

  function automatic logic port_ack(input int p);
    return (p == 0) ? m0_ack : m1_ack;
  endfunction

  function automatic logic port_err(input int p);
    return (p == 0) ? m0_err : m1_err;
  endfunction

  function automatic logic [31:0] port_rdata(input int p);
    return (p == 0) ? m0_rdata : m1_rdata;
  endfunction

  // One access on port p, starting and ending at a falling edge with the DUT idle.
  task automatic access(input string tag, input int p, input logic we, input logic [1:0] sz,
                        input logic [ADDR_W-1:0] addr, input logic [31:0] wd);
    bit                e, acked;
    int                lat, n_cs, n_r, n_wb, n_wh, n_ww, n_other;
    logic              got_err;
    logic [31:0]       got_rd, exp_rd, other_rd0, seen_din;
    logic [ADDR_W-1:0] seen_addr;

    e         = model_err(sz, int'(addr));
    exp_rd    = e ? 32'b0 : model_load(sz, int'(addr));
    other_rd0 = port_rdata(1 - p);
    acked = 1'b0; lat = 0; n_cs = 0; n_r = 0; n_wb = 0; n_wh = 0; n_ww = 0; n_other = 0;
    got_err = 1'b0; got_rd = '0; seen_addr = '0; seen_din = '0;

    drive_port(p, 1'b1, we, sz, addr, wd);
    while (!acked && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      // Request fields change after grant; the in-flight access must not notice.
      if (lat == 1) drive_port(p, 1'b1, ~we, 2'($urandom), ADDR_W'($urandom), $urandom);
      if (cs) begin
        n_cs++;
        seen_addr = DM_addr;
        seen_din  = DM_data_in;
      end
      n_r  += int'(DM_R);
      n_wb += int'(DM_W_B);
      n_wh += int'(DM_W_H);
      n_ww += int'(DM_W_W);
      if (port_ack(1 - p)) n_other++;
      if (port_ack(p)) begin
        acked   = 1'b1;
        got_err = port_err(p);
        got_rd  = port_rdata(p);
        drive_port(p, 1'b0, 1'b0, 2'b00, '0, '0);
      end
    end
    if (!acked) drive_port(p, 1'b0, 1'b0, 2'b00, '0, '0);

    check({tag, "/acked"}, 32'(acked), 32'd1);
    check({tag, "/latency"}, 32'(lat), e ? 32'd1 : 32'd2);
    check({tag, "/err"}, 32'(got_err), 32'(e));
    if (e || !we) check({tag, "/rdata"}, got_rd, exp_rd);
    check({tag, "/cs_cycles"}, 32'(n_cs), e ? 32'd0 : 32'd1);
    check({tag, "/rd_cycles"}, 32'(n_r), 32'(!e && !we));
    check({tag, "/wb_cycles"}, 32'(n_wb), 32'(!e && we && sz == 2'b00));
    check({tag, "/wh_cycles"}, 32'(n_wh), 32'(!e && we && sz == 2'b01));
    check({tag, "/ww_cycles"}, 32'(n_ww), 32'(!e && we && sz == 2'b10));
    check({tag, "/other_ack"}, 32'(n_other), 32'd0);
    if (!e) check({tag, "/dm_addr"}, 32'(seen_addr), 32'(addr));
    if (!e && we) check({tag, "/dm_data_in"}, seen_din, wd);
    if (!e && we) model_store(sz, int'(addr), wd);

    @(posedge clk);
    @(negedge clk);
    check({tag, "/idle_after"}, 32'(busy), 32'd0);
    check({tag, "/other_rdata_held"}, port_rdata(1 - p), other_rd0);
  endtask

  // Invariants that hold in every cycle outside reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("acks_exclusive", 32'(m0_ack & m1_ack), 32'd0);
      check("strobe_exclusive", 32'($countones({DM_R, DM_W_B, DM_W_H, DM_W_W}) > 1), 32'd0);
      check("strobe_needs_cs", 32'(!cs && (DM_R || DM_W_B || DM_W_H || DM_W_W)), 32'd0);
    end
  end

  initial begin
    int          cyc, n, simul, exp_port, n_ack;
    int          ports [4];
    int          cycs  [4];

    rst = 1'b1;
    drive_port(0, 1'b0, 1'b0, 2'b00, '0, '0);
    drive_port(1, 1'b0, 1'b0, 2'b00, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/mem_ctrl", 32'({cs, DM_R, DM_W_W, DM_W_H, DM_W_B}), 32'd0);
    check("reset/ack_err", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
    check("reset/rdata0", m0_rdata, 32'd0);
    check("reset/rdata1", m1_rdata, 32'd0);
    check("reset/dm_addr", 32'(DM_addr), 32'd0);
    check("reset/dm_data_in", DM_data_in, 32'd0);
    rst = 1'b0;

    access("word_store", 0, 1'b1, 2'b10, 11'h010, 32'hDEADBEEF);
    access("word_load",  0, 1'b0, 2'b10, 11'h010, 32'h0);

    access("byte_store", 0, 1'b1, 2'b00, 11'h013, 32'hFFFFFFA5);
    access("half_store", 1, 1'b1, 2'b01, 11'h016, 32'hFFFF1234);
    access("sub_word_load", 0, 1'b0, 2'b10, 11'h014, 32'h0);
    access("byte_load", 1, 1'b0, 2'b00, 11'h013, 32'h0);
    access("word_reload", 1, 1'b0, 2'b10, 11'h010, 32'h0);

    access("err_half_odd",  0, 1'b0, 2'b01, 11'h011, 32'h0);
    access("err_word_high", 1, 1'b1, 2'b10, 11'h402, 32'h12345678);
    access("err_size3",     0, 1'b1, 2'b11, 11'h020, 32'h55AA55AA);

    access("edge_word_store", 1, 1'b1, 2'b10, 11'h3FC, 32'h89ABCDEF);
    access("edge_word_load",  0, 1'b0, 2'b10, 11'h3FC, 32'h0);
    access("edge_word_3fd",   0, 1'b0, 2'b10, 11'h3FD, 32'h0);
    access("edge_half_3fe",   1, 1'b0, 2'b01, 11'h3FE, 32'h0);
    access("edge_byte_3ff",   0, 1'b0, 2'b00, 11'h3FF, 32'h0);
    access("edge_word_400",   1, 1'b0, 2'b10, 11'h400, 32'h0);

    // Reset lands while a store is in ACCESS: the write still commits, no ack follows.
    drive_port(0, 1'b1, 1'b1, 2'b10, 11'h200, 32'hCAFEF00D);
    @(posedge clk);
    @(negedge clk);
    check("rst_access/in_access", 32'({cs, DM_W_W}), 32'b11);
    rst = 1'b1;
    drive_port(0, 1'b0, 1'b0, 2'b00, '0, '0);
    @(posedge clk);
    @(negedge clk);
    check("rst_access/busy", 32'(busy), 32'd0);
    check("rst_access/mem_ctrl", 32'({cs, DM_R, DM_W_W, DM_W_H, DM_W_B}), 32'd0);
    check("rst_access/ack", 32'({m0_ack, m1_ack}), 32'd0);
    check("rst_access/rdata0", m0_rdata, 32'd0);
    rst = 1'b0;
    model_store(2'b10, 'h200, 32'hCAFEF00D);
    n_ack = 0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (m0_ack || m1_ack) n_ack++;
    end
    check("rst_access/no_ack", 32'(n_ack), 32'd0);
    access("rst_access/reload", 1, 1'b0, 2'b10, 11'h200, 32'h0);

    // Both ports hold req from reset: grants must alternate starting with port 0.
    rst = 1'b1;
    drive_port(0, 1'b1, 1'b0, 2'b10, 11'h010, 32'h0);
    drive_port(1, 1'b1, 1'b0, 2'b10, 11'h3FC, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0; n = 0; simul = 0;
    while (n < 4 && cyc < 30) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (m0_ack && m1_ack) simul++;
      else if (m0_ack || m1_ack) begin
        ports[n] = m1_ack ? 1 : 0;
        cycs[n]  = cyc;
        check("contend/rdata", port_rdata(ports[n]), model_load(2'b10, (ports[n] == 0) ? 'h010 : 'h3FC));
        n++;
      end
    end
    drive_port(0, 1'b0, 1'b0, 2'b00, '0, '0);
    drive_port(1, 1'b0, 1'b0, 2'b00, '0, '0);
    check("contend/ack_count", 32'(n), 32'd4);
    check("contend/simultaneous", 32'(simul), 32'd0);
    exp_port = 0;
    for (int k = 0; k < n; k++) begin
      check("contend/port", 32'(ports[k]), 32'(exp_port));
      exp_port = 1 - exp_port;
      if (k == 0) check("contend/first_ack_cycle", 32'(cycs[0]), 32'd2);
      else        check("contend/ack_spacing", 32'(cycs[k] - cycs[k-1]), 32'd3);
    end
    @(posedge clk);
    @(negedge clk);
    check("contend/idle_after", 32'(busy), 32'd0);

    for (int k = 0; k < 80; k++) begin
      int         p, a, sel_a;
      logic       we;
      logic [1:0] sz;
      p  = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      sel_a = int'($urandom_range(0, 7));
      if (sel_a == 0)      a = int'($urandom_range(0, 2047));
      else if (sel_a == 1) a = 1016 + int'($urandom_range(0, 15));
      else                 a = 'h100 + int'($urandom_range(0, 31));
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a - (a % nbytes(sz));
      access("random", p, we, sz, ADDR_W'(a), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
